// File: rtl/sstv_tx.sv
// SSTV frame transmitter: leader/break/VIS header followed by a 2-bpp image, one frequency word per clock.
// Optional per-line sync tone enabled by defining SSTV_TX_HSYNC_EN.
module sstv_tx #(
    parameter int T_LEADER = 30000,
    parameter int T_BREAK  = 1000,
    parameter int T_BIT    = 3000,
    parameter int T_PIXEL  = 35,
    parameter int T_HSYNC  = 50,
    parameter int H_PIXELS = 160,
    parameter int V_LINES  = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  vis_code,
    output logic [14:0] vid_addr,
    input  logic [1:0]  vid_pixel,
    output logic [11:0] freq,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        S_IDLE, S_LEAD1, S_BREAK, S_LEAD2, S_VSTART, S_VBITS,
        S_VSTOP, S_HSYNC, S_PIXEL, S_FIN
    } state_t;

    localparam logic [11:0] F_LEAD = 12'd1900;
    localparam logic [11:0] F_SYNC = 12'd1200;
    localparam logic [14:0] PIX_LAST = 15'(H_PIXELS * V_LINES - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] last_cnt;
    logic        at_end;
    logic [7:0]  vis_reg;
    logic [2:0]  bit_idx;
    logic [14:0] pix_idx;
    logic [14:0] pix_next;
`ifdef SSTV_TX_HSYNC_EN
    logic [14:0] col;
`endif

    function automatic logic [11:0] pixel_tone(input logic [1:0] p);
        case (p)
            2'd0:    return 12'd1500;
            2'd1:    return 12'd1767;
            2'd2:    return 12'd2033;
            default: return 12'd2300;
        endcase
    endfunction

    function automatic logic [11:0] vis_tone(input logic b);
        return b ? 12'd1100 : 12'd1300;
    endfunction

    // Address one pixel ahead of x, pinned at the final pixel so it never wraps.
    function automatic logic [14:0] prefetch(input logic [14:0] x);
        return (x >= PIX_LAST) ? PIX_LAST : x + 15'd1;
    endfunction

    always_comb begin
        last_cnt = '0;
        case (state)
            S_LEAD1, S_LEAD2:          last_cnt = 16'(T_LEADER - 1);
            S_BREAK:                   last_cnt = 16'(T_BREAK - 1);
            S_VSTART, S_VBITS, S_VSTOP: last_cnt = 16'(T_BIT - 1);
            S_HSYNC:                   last_cnt = 16'(T_HSYNC - 1);
            S_PIXEL:                   last_cnt = 16'(T_PIXEL - 1);
            default:                   last_cnt = '0;
        endcase
    end

    assign at_end   = (cnt == last_cnt);
    assign pix_next = pix_idx + 15'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            vis_reg  <= '0;
            bit_idx  <= '0;
            pix_idx  <= '0;
            vid_addr <= '0;
            freq     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef SSTV_TX_HSYNC_EN
            col      <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (state != S_IDLE && state != S_FIN)
                cnt <= at_end ? '0 : cnt + 16'd1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LEAD1;
                        freq     <= F_LEAD;
                        busy     <= 1'b1;
                        vis_reg  <= {^vis_code, vis_code};
                        bit_idx  <= '0;
                        pix_idx  <= '0;
                        vid_addr <= '0;
                        cnt      <= '0;
                    end
                end
                S_LEAD1: if (at_end) begin
                    state <= S_BREAK;
                    freq  <= F_SYNC;
                end
                S_BREAK: if (at_end) begin
                    state <= S_LEAD2;
                    freq  <= F_LEAD;
                end
                S_LEAD2: if (at_end) begin
                    state <= S_VSTART;
                    freq  <= F_SYNC;
                end
                S_VSTART: if (at_end) begin
                    state <= S_VBITS;
                    freq  <= vis_tone(vis_reg[0]);
                end
                S_VBITS: if (at_end) begin
                    if (bit_idx == 3'd7) begin
                        state <= S_VSTOP;
                        freq  <= F_SYNC;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        vis_reg <= vis_reg >> 1;
                        freq    <= vis_tone(vis_reg[1]);
                    end
                end
                S_VSTOP: if (at_end) begin
`ifdef SSTV_TX_HSYNC_EN
                    state <= S_HSYNC;
                    freq  <= F_SYNC;
                    col   <= '0;
`else
                    state    <= S_PIXEL;
                    freq     <= pixel_tone(vid_pixel);
                    vid_addr <= prefetch(pix_idx);
`endif
                end
                S_HSYNC: if (at_end) begin
                    // vid_addr already points at the line's first pixel; its data is ready now.
                    state    <= S_PIXEL;
                    freq     <= pixel_tone(vid_pixel);
                    vid_addr <= prefetch(pix_idx);
                end
                S_PIXEL: if (at_end) begin
                    if (pix_idx == PIX_LAST) begin
                        state <= S_FIN;
                        freq  <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        pix_idx <= pix_next;
`ifdef SSTV_TX_HSYNC_EN
                        if (col == 15'(H_PIXELS - 1)) begin
                            state <= S_HSYNC;
                            freq  <= F_SYNC;
                            col   <= '0;
                        end else begin
                            col      <= col + 15'd1;
                            freq     <= pixel_tone(vid_pixel);
                            vid_addr <= prefetch(pix_next);
                        end
`else
                        freq     <= pixel_tone(vid_pixel);
                        vid_addr <= prefetch(pix_next);
`endif
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    freq  <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sstv_tx.sv
// Directed bench for sstv_tx with shrunk timing parameters; a 1-cycle RAM model supplies pixels.
module tb_sstv_tx;

    localparam int TL = 20;
    localparam int TB = 5;
    localparam int TBIT = 6;
    localparam int TP = 4;
    localparam int TH = 3;
    localparam int HP = 4;
    localparam int VL = 3;
    localparam int NPIX = HP * VL;
`ifdef SSTV_TX_HSYNC_EN
    localparam int FRAME = 2*TL + TB + 10*TBIT + NPIX*TP + VL*TH;
`else
    localparam int FRAME = 2*TL + TB + 10*TBIT + NPIX*TP;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  vis_code = 7'h08;
    logic [14:0] vid_addr;
    logic [1:0]  vid_pixel = 2'd0;
    logic [11:0] freq;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;

    logic [11:0] exp_freq [0:FRAME+1];
    int slot_start [0:NPIX-1];
    int vstop_start;
    int n;

    sstv_tx #(
        .T_LEADER(TL), .T_BREAK(TB), .T_BIT(TBIT), .T_PIXEL(TP),
        .T_HSYNC(TH), .H_PIXELS(HP), .V_LINES(VL)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .vis_code(vis_code),
        .vid_addr(vid_addr), .vid_pixel(vid_pixel),
        .freq(freq), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] pix_of(input logic [14:0] a);
        return a[1:0] ^ a[3:2];
    endfunction

    function automatic logic [11:0] tone_of(input logic [1:0] p);
        logic [11:0] t [0:3];
        t = '{12'd1500, 12'd1767, 12'd2033, 12'd2300};
        return t[p];
    endfunction

    always @(posedge clk) vid_pixel <= pix_of(vid_addr);

    task automatic push(input logic [11:0] f, input int len);
        for (int i = 0; i < len; i++) begin
            exp_freq[n] = f;
            n++;
        end
    endtask

    task automatic build_expected(input logic [6:0] vis);
        logic [7:0] v;
        v = {^vis, vis};
        n = 1;
        push(12'd1900, TL);
        push(12'd1200, TB);
        push(12'd1900, TL);
        push(12'd1200, TBIT);
        for (int i = 0; i < 8; i++) push(v[i] ? 12'd1100 : 12'd1300, TBIT);
        vstop_start = n;
        push(12'd1200, TBIT);
        for (int p = 0; p < NPIX; p++) begin
`ifdef SSTV_TX_HSYNC_EN
            if (p % HP == 0) push(12'd1200, TH);
`endif
            slot_start[p] = n;
            push(tone_of(pix_of(15'(p))), TP);
        end
        exp_freq[FRAME+1] = 12'd0;
    endtask

    // Runs one frame; dist_k > 1 re-asserts start and changes vis_code at that cycle.
    // collide raises start exactly during the FIN cycle.
    task automatic run_frame(input logic [6:0] vis, input int dist_k, input bit collide, input string tag);
        int dones;
        int p;
        logic [14:0] ea;
        build_expected(vis);
        @(negedge clk);
        start = 1'b1;
        vis_code = vis;
        dones = 0;
        p = 0;
        for (int k = 1; k <= FRAME + 1; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done) dones++;
            total++;
            if (freq !== exp_freq[k]) begin
                bad++;
                $display("FAIL %s freq k=%0d got=%0d want=%0d", tag, k, freq, exp_freq[k]);
            end
            total++;
            if (busy !== (k <= FRAME) || done !== (k == FRAME + 1)) begin
                bad++;
                $display("FAIL %s busy/done k=%0d got=%b/%b want=%b/%b", tag, k, busy, done,
                         k <= FRAME, k == FRAME + 1);
            end
            if (k >= vstop_start && k < vstop_start + TBIT) begin
                total++;
                if (vid_addr !== 15'd0) begin
                    bad++;
                    $display("FAIL %s vstop_addr k=%0d got=%0d want=0", tag, k, vid_addr);
                end
            end
            if (p < NPIX && k == slot_start[p]) begin
                ea = (p + 1 < NPIX) ? 15'(p + 1) : 15'(NPIX - 1);
                total++;
                if (vid_addr !== ea) begin
                    bad++;
                    $display("FAIL %s prefetch_addr pixel=%0d got=%0d want=%0d", tag, p, vid_addr, ea);
                end
                p++;
            end
            if (dist_k > 1 && k == dist_k) begin
                start = 1'b1;
                vis_code = 7'h7F;
            end
            if (dist_k > 1 && k == dist_k + 1) start = 1'b0;
            if (collide && k == FRAME + 1) start = 1'b1;
        end
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL %s done_count got=%0d want=1", tag, dones);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            total++;
            if (freq !== 12'd0 || busy !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("FAIL %s idle_after k=%0d got freq=%0d busy=%b done=%b want 0/0/0",
                         tag, k, freq, busy, done);
            end
        end
        $display("frame %s vis=%02h cycles=%0d done_pulses=%0d", tag, vis, FRAME, dones);
        vis_code = 7'h08;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (freq !== 12'd0 || busy !== 1'b0 || done !== 1'b0 || vid_addr !== 15'd0) begin
            bad++;
            $display("FAIL reset_held got freq=%0d busy=%b done=%b addr=%0d want 0", freq, busy, done, vid_addr);
        end
        reset = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            total++;
            if (freq !== 12'd0 || busy !== 1'b0 || done !== 1'b0 || vid_addr !== 15'd0) begin
                bad++;
                $display("FAIL reset_idle k=%0d got freq=%0d busy=%b done=%b addr=%0d want 0",
                         k, freq, busy, done, vid_addr);
            end
        end
        $display("reset: idle held 1000 cycles");
    endtask

    task automatic test_header_vis();
        run_frame(7'h08, 0, 1'b0, "vis08");
    endtask

    task automatic test_other_code();
        run_frame(7'h55, 0, 1'b0, "vis55");
    endtask

    task automatic test_ignore();
        run_frame(7'h08, 60, 1'b0, "ignore");
    endtask

    task automatic test_start_done_collision();
        run_frame(7'h08, 0, 1'b1, "collide");
    endtask

    task automatic test_async_reset();
        build_expected(7'h08);
        @(negedge clk);
        start = 1'b1;
        vis_code = 7'h08;
        @(negedge clk);
        start = 1'b0;
        repeat (slot_start[5]) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL async_pre busy got=%b want=1", busy);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (freq !== 12'd0 || busy !== 1'b0 || done !== 1'b0 || vid_addr !== 15'd0) begin
            bad++;
            $display("FAIL async_reset got freq=%0d busy=%b done=%b addr=%0d want 0",
                     freq, busy, done, vid_addr);
        end
        $display("async reset: freq=%0d busy=%b", freq, busy);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (freq !== 12'd0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL async_no_done got freq=%0d busy=%b done=%b want 0/0/0", freq, busy, done);
        end
        run_frame(7'h08, 0, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_header_vis();
        test_other_code();
        test_ignore();
        test_start_done_collision();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sstv_tx.md
# sstv_tx

SSTV frame transmitter: on `start`, emits the tone sequence an SSTV receiver expects as a 12-bit frequency word, one word per clock. The sequence is leader, break, leader, VIS start bit, 7 VIS data bits plus parity, VIS stop bit, then a 160×120 2-bit-per-pixel image read from video memory. It sits between the framebuffer and the tone synthesizer (NCO), and can drive the receiver's `freq` input directly for loopback.

## Interface

- `T_LEADER`, 30000: leader tone length, clocks (300 ms at 100 kHz tick).
- `T_BREAK`, 1000: break tone length, clocks.
- `T_BIT`, 3000: VIS start/data/parity/stop bit length, clocks.
- `T_PIXEL`, 35: pixel tone length, clocks.
- `T_HSYNC`, 50: line-sync length, clocks (used only with `SSTV_TX_HSYNC_EN`).
- `H_PIXELS`, 160: pixels per line.
- `V_LINES`, 120: lines per frame.

Ports (clock is `clk`, reset is `reset`, one clock domain; reset is asynchronous and active-high):

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a frame; sampled only in IDLE.
- `vis_code`  in  7  VIS mode code; latched on accepted `start`.
- `vid_addr`  out  15  linear pixel address, 0..H_PIXELS*V_LINES-1.
- `vid_pixel`  in  2  pixel value returned for `vid_addr`.
- `freq`  out  12  tone frequency in Hz, registered.
- `busy`  out  1  high from first tone cycle through last pixel cycle.
- `done`  out  1  one-cycle pulse after last pixel.

## Operation

- States: IDLE, LEAD1, BREAK, LEAD2, VSTART, VBITS, VSTOP, (HSYNC), PIXEL, FIN.
- Tones: LEAD1/LEAD2 = 1900, BREAK/VSTART/VSTOP/HSYNC = 1200, VIS bit 1 = 1100, VIS bit 0 = 1300, IDLE/FIN = 0.
- VIS: 8 bits, LSB first. Bits 0–6 are `vis_code`; bit 7 is even parity (XOR of bits 0–6). Code 0x08 transmits 0x88.
- Pixel tone: 0→1500, 1→1767, 2→2033, 3→2300. Fixed lookup, no arithmetic.
- Pixel order: linear, `vid_addr` = line*H_PIXELS + column. 15-bit counter, stops at H_PIXELS*V_LINES-1 with no wrap.
- Memory contract: `vid_pixel` must be valid by the cycle after `vid_addr` changes (1-cycle synchronous RAM).
- Prefetch: `vid_addr` for pixel N+1 is driven from the first cycle of slot N. During VSTOP (or the preceding HSYNC) it holds 0. `vid_pixel` is registered on the last cycle of the preceding slot.
- `start` while busy: ignored. `vis_code` changes after acceptance: no effect on the frame.
- FIN lasts one cycle: `done`=1, `busy`=0, `freq`=0, then IDLE.
- Simultaneous `start` and `done`: the `start` is ignored, because FIN is not IDLE.

## Timing

- Reset values: `freq`=0, `busy`=0, `done`=0, `vid_addr`=0. State is IDLE.
- Reset mid-frame: all outputs return to reset values asynchronously. There is no partial completion and no `done`.
- `start` high at rising edge t in IDLE: from cycle t+1, `freq`=1900 and `busy`=1.
- Each tone lasts exactly its parameter count of cycles. Transitions have no gap cycles.
- Default frame without HSYNC: 30000+1000+30000+3000+8·3000+3000+19200·35 = 763000 busy cycles. `done` arrives at cycle t+763001.
- Pixel N's tone starts 1 cycle after its address was held for ≥T_PIXEL−1 cycles, giving a minimum read latency margin of 1 cycle.

## Configuration

- `SSTV_TX_HSYNC_EN` defined:
  - HSYNC state (1200 Hz, T_HSYNC cycles) inserted before every line, including line 0 after VSTOP.
  - Default frame becomes 763000 + 120·50 = 769000 cycles.
- Undefined: no line sync. Pixels run contiguously across line boundaries, matching the current receiver.

## Test plan

- Reset: hold `reset` 10 cycles, release with `start`=0 → `freq`=0, `busy`=0, `done`=0, `vid_addr`=0, stable for 1000 cycles.
- Header/VIS: `start` pulse with `vis_code`=0x08 → 1900×30000, 1200×1000, 1900×30000, 1200×3000, then per 3000 cycles 1300,1300,1300,1100,1300,1300,1300,1100, then 1200×3000.
- Pixels: memory returns `vid_addr[1:0]` → `freq` cycles 1500,1767,2033,2300 in 35-cycle slots. Last `vid_addr`=19199. `done` is a single pulse at cycle t+763001, followed by `freq`=0.
- Ignore rules: second `start` during VIS and `vis_code` changed to 0x7F mid-frame → waveform identical to the 0x08 run, single `done`.
- Async reset at pixel 5000: `freq`=0 and `busy`=0 without waiting for a clock edge. A new `start` then produces a full 763000-cycle frame from the leader.
- `SSTV_TX_HSYNC_EN` build: 1200×50 before pixels 0, 160, 320, … (120 pulses). `done` at t+769001.
